// File: rtl/rx_buf_pkg.sv
// Shared types and sizing helpers for the receive message buffer.
package rx_buf_pkg;

  // Write-handshake FSM states.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WRITE    = 2'd1,
    ACK      = 2'd2,
    WAIT_LOW = 2'd3
  } wr_state_e;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned RX_ADDR_W  = 16;
  localparam int unsigned RX_LEN_W   = 16;
  localparam int unsigned ADDR_W_DEF = 8;

  // Buffer depth in bytes for a given address width.
  function automatic int unsigned ram_depth(input int unsigned addr_w);
    return 32'(1) << addr_w;
  endfunction

  localparam int unsigned RAM_DEPTH_DEF = ram_depth(ADDR_W_DEF);

  // Saturation value of the written-byte counter.
  localparam logic [RX_LEN_W-1:0] WCNT_SAT = '1;

endpackage

// File: rtl/rx_buf_ram.sv
// Simple dual-port byte RAM: one write port, one registered read port.
module rx_buf_ram
  import rx_buf_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [BYTE_W-1:0] i_wr_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [BYTE_W-1:0] o_rd_data
);

  localparam int unsigned DEPTH = ram_depth(ADDR_W);

  logic [BYTE_W-1:0] r_mem [DEPTH];
  logic [BYTE_W-1:0] r_rd_data;

  // Storage array, no reset so it maps onto a RAM macro.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  // Registered read port, cleared by reset so the output starts at zero.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) r_rd_data <= '0;
    else        r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/rx_message_buffer.sv
// Single-message receive buffer: acknowledges every receiver write, stores
// the message, and publishes it to the host only when it ends cleanly.
module rx_message_buffer
  import rx_buf_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned ERR_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_l,
  input  logic [BYTE_W-1:0]    rx_flag,
  input  logic [RX_LEN_W-1:0]  rx_byte_number,
  input  logic                 rx_flag_byte_number_rd_en,
  input  logic                 rx_ram_req_wr,
  output logic                 rx_ram_rdy_wr,
  input  logic [RX_ADDR_W-1:0] rx_ram_addr,
  input  logic [BYTE_W-1:0]    rx_ram_data,
  input  logic                 rx_end_message,
  input  logic                 rx_message_right,
  input  logic                 rx_end_message_line,
  output logic                 msg_valid,
  output logic [BYTE_W-1:0]    msg_flag,
  output logic [RX_LEN_W-1:0]  msg_len,
  output logic                 msg_line,
  input  logic [ADDR_W-1:0]    msg_rd_addr,
  output logic [BYTE_W-1:0]    msg_rd_data,
  input  logic                 msg_ack,
  output logic [ERR_W-1:0]     err_cnt,
  output logic [ERR_W-1:0]     drop_cnt
);

  localparam int unsigned      DEPTH   = ram_depth(ADDR_W);
  localparam logic [ERR_W-1:0] ERR_SAT = '1;

  wr_state_e r_state, w_state_nxt;
  logic      r_rdy_wr;

  logic [BYTE_W-1:0]   r_sh_flag;
  logic [RX_LEN_W-1:0] r_sh_len;
  logic [RX_LEN_W-1:0] r_wcnt;
  logic                r_ovf;
  logic                r_mid;
  logic                r_occ;

  logic                r_msg_valid;
  logic [BYTE_W-1:0]   r_msg_flag;
  logic [RX_LEN_W-1:0] r_msg_len;
  logic                r_msg_line;
  logic [ERR_W-1:0]    r_err_cnt;
  logic [ERR_W-1:0]    r_drop_cnt;

  logic w_in_write, w_in_range, w_commit, w_good, w_drop;

  assign w_in_write = (r_state == WRITE);
  assign w_in_range = (32'(rx_ram_addr) < DEPTH);
  assign w_commit   = w_in_write && !r_msg_valid && w_in_range;
  assign w_good     = r_mid && rx_message_right && !r_ovf && !r_occ && (r_wcnt == r_sh_len);
  assign w_drop     = r_mid && rx_message_right && r_occ;

  // Write-handshake state register; ack is high for the cycle spent in ACK.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_state  <= IDLE;
      r_rdy_wr <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_rdy_wr <= w_in_write;
    end
  end

  // Next-state: one write per request, then wait for the request to drop.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:     if (rx_ram_req_wr) w_state_nxt = WRITE;
      WRITE:    w_state_nxt = ACK;
      ACK:      w_state_nxt = WAIT_LOW;
      WAIT_LOW: if (!rx_ram_req_wr) w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  // Per-message shadow descriptor, overflow flag and written-byte count.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_sh_flag <= '0;
      r_sh_len  <= '0;
      r_wcnt    <= '0;
      r_ovf     <= 1'b0;
      r_mid     <= 1'b0;
      r_occ     <= 1'b0;
    end else if (rx_flag_byte_number_rd_en) begin
      r_sh_flag <= rx_flag;
      r_sh_len  <= rx_byte_number;
      r_wcnt    <= '0;
      r_ovf     <= 1'b0;
      r_mid     <= 1'b1;
      r_occ     <= r_msg_valid;
    end else begin
      if (w_commit && (r_wcnt != WCNT_SAT)) r_wcnt <= r_wcnt + RX_LEN_W'(1);
      if (w_in_write && !w_in_range)        r_ovf  <= 1'b1;
      if (rx_end_message)                   r_mid  <= 1'b0;
    end
  end

  // Host-visible message state: publish on a good end, release on ack.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_msg_valid <= 1'b0;
      r_msg_flag  <= '0;
      r_msg_len   <= '0;
      r_msg_line  <= 1'b0;
    end else if (rx_end_message && w_good) begin
      r_msg_valid <= 1'b1;
      r_msg_flag  <= r_sh_flag;
      r_msg_len   <= r_sh_len;
      r_msg_line  <= rx_end_message_line;
    end else if (msg_ack && r_msg_valid) begin
      r_msg_valid <= 1'b0;
    end
  end

  // Saturating error and drop counters.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_err_cnt  <= '0;
      r_drop_cnt <= '0;
    end else if (rx_end_message && !w_good) begin
      if (w_drop) begin
        if (r_drop_cnt != ERR_SAT) r_drop_cnt <= r_drop_cnt + ERR_W'(1);
      end else begin
        if (r_err_cnt != ERR_SAT) r_err_cnt <= r_err_cnt + ERR_W'(1);
      end
    end
  end

  rx_buf_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk       (clk),
    .rst_l     (rst_l),
    .i_wr_en   (w_commit),
    .i_wr_addr (rx_ram_addr[ADDR_W-1:0]),
    .i_wr_data (rx_ram_data),
    .i_rd_addr (msg_rd_addr),
    .o_rd_data (msg_rd_data)
  );

  assign rx_ram_rdy_wr = r_rdy_wr;
  assign msg_valid     = r_msg_valid;
  assign msg_flag      = r_msg_flag;
  assign msg_len       = r_msg_len;
  assign msg_line      = r_msg_line;
  assign err_cnt       = r_err_cnt;
  assign drop_cnt      = r_drop_cnt;

endmodule

// File: doc/rx_message_buffer.md
Name: rx_message_buffer

Overview:
- Downstream stage of the high-speed protocol receiver; consumes its RAM-write handshake, message descriptor and end-of-message status.
- Stores one received message in an internal byte RAM and latches its flag, byte count and receive line.
- Publishes the message to a host-side reader only if it ends correctly; otherwise discards it and counts the error.
- Keeps the receiver free-running: every write request is acknowledged, including writes that are dropped.

Parameters:
- ADDR_W, 8, buffer address width; depth = 2**ADDR_W bytes
- ERR_W, 8, width of saturating error/drop counters

Ports:
- clk  in  1  system clock
- rst_l  in  1  asynchronous reset, active-low
- rx_flag  in  8  message flag/status from receiver
- rx_byte_number  in  16  data byte count of message
- rx_flag_byte_number_rd_en  in  1  one-cycle strobe: rx_flag/rx_byte_number valid
- rx_ram_req_wr  in  1  write request (level, held until ack)
- rx_ram_rdy_wr  out  1  write acknowledge pulse
- rx_ram_addr  in  16  write byte address
- rx_ram_data  in  8  write byte
- rx_end_message  in  1  one-cycle strobe: message finished
- rx_message_right  in  1  qualifies rx_end_message: 1 = good
- rx_end_message_line  in  1  0 = COM1, 1 = COM2
- msg_valid  out  1  stored message available to host
- msg_flag  out  8  latched flag
- msg_len  out  16  latched byte count
- msg_line  out  1  latched line
- msg_rd_addr  in  ADDR_W  host read address
- msg_rd_data  out  8  host read data, 1-cycle latency
- msg_ack  in  1  host releases buffer
- err_cnt  out  ERR_W  bad messages (right=0, overflow or length mismatch)
- drop_cnt  out  ERR_W  good messages lost because buffer was occupied

Behaviour:
- Reset (async, rst_l=0): all outputs 0, counters 0, FSM IDLE, msg_valid=0; RAM contents undefined.
- Write FSM: IDLE -> WRITE when rx_ram_req_wr=1 -> ACK (rx_ram_rdy_wr=1 for exactly one cycle) -> WAIT_LOW until rx_ram_req_wr=0 -> IDLE. Each request yields exactly one write and one ack; a request held high never causes a second write.
- WRITE commits rx_ram_data at rx_ram_addr[ADDR_W-1:0] only if the buffer is open (msg_valid=0) and rx_ram_addr < 2**ADDR_W. Otherwise the write is suppressed but still acknowledged.
- Writes with rx_ram_addr >= 2**ADDR_W set the per-message overflow bit.
- Per-message tracking:
  - rx_flag_byte_number_rd_en latches the flag and byte count into shadow registers, clears the overflow bit and the written-byte counter (16-bit, saturating), and sets a mid-message flag.
  - Each committed write increments the written-byte counter.
- On rx_end_message:
  - good = rx_message_right and no overflow and written count == latched byte count and msg_valid=0 at start of message.
  - good: next cycle msg_valid=1 and msg_flag/msg_len/msg_line are loaded from the shadow registers and rx_end_message_line.
  - right=1 but buffer occupied at start of message: drop_cnt+1.
  - any other case: err_cnt+1.
  - Counters saturate at all-ones.
- rx_end_message without a preceding descriptor strobe counts as an error.
- Host side:
  - msg_rd_data is RAM[msg_rd_addr] registered, 1-cycle latency, readable at any time.
  - msg_ack while msg_valid=1 clears msg_valid next cycle; msg_ack while msg_valid=0 is ignored.
- Simultaneous events:
  - msg_ack in the same cycle as a descriptor strobe: the new message counts as occupied (open state is sampled before the ack takes effect).
  - msg_ack in the same cycle as a good rx_end_message cannot occur for a writable message.
- Reset mid-handshake returns the FSM to IDLE. A request still high after reset is treated as a new request.

Decomposition:
- Package rx_buf_pkg: FSM state enum (IDLE, WRITE, ACK, WAIT_LOW), the counter saturation constant, and the RAM depth localparam derived from ADDR_W.
- Sub-module rx_buf_ram: simple dual-port RAM (one write port, one registered read port), 2**ADDR_W x 8, inferable.

Test Plan:
- Descriptor flag=8'h5A, len=4; writes addr 0..3 data 11,22,33,44; end with right=1, line=1 -> one ack per write; msg_valid=1, msg_flag=5A, msg_len=4, msg_line=1; reads of addr 0..3 return 11..44 one cycle after the address.
- Same message with end right=0 -> msg_valid stays 0, err_cnt=1.
- len=3 but only 2 writes, right=1 -> err_cnt=1, msg_valid=0.
- ADDR_W=4, write at addr 16 -> ack still given, overflow set; end right=1 -> err_cnt=1.
- Valid message left unacked, second good message arrives -> its writes are acked but the RAM is unchanged, drop_cnt=1; after msg_ack, msg_valid=0.
- rx_ram_req_wr held high 10 cycles -> exactly one rx_ram_rdy_wr pulse. rst_l pulsed low during ACK -> all outputs 0 immediately.
